// File: rtl/match_collector.sv
// -----------------------------------------------------------------------------
// match_collector
//
// Buffers the per-pair match stream from the matching stage in a show-ahead
// FIFO, presents it on a ready/valid interface, and accumulates per-frame
// statistics (pair count, sum of dx, sum of dy, drops). One summary strobe is
// emitted per frame, after the last pair of that frame has left the FIFO.
//
// Ports
//   i_clk, i_rst        clock (rising edge), asynchronous active-high reset
//   i_valid             one match pair this cycle (no upstream backpressure)
//   i_src_x/y, i_dst_x/y  pair coordinates
//   i_end               single-cycle end-of-frame pulse
//   i_ready             downstream ready
//   o_valid, o_src_x/y, o_dst_x/y  FIFO head (show-ahead)
//   o_sum_valid         one-cycle frame summary strobe
//   o_match_cnt         pairs seen in the frame (accepted + dropped)
//   o_drop_cnt          pairs dropped because the FIFO was full
//   o_sum_dx, o_sum_dy  signed sums of (dst - src)
//   o_err               sticky: i_end seen outside ACCUM
// -----------------------------------------------------------------------------
module match_collector #(
  parameter int DEPTH  = 16,
  parameter int COOR_W = 10,
  parameter int CNT_W  = 12,
  parameter int SUM_W  = 22
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [COOR_W-1:0] i_src_x,
  input  logic [COOR_W-1:0] i_src_y,
  input  logic [COOR_W-1:0] i_dst_x,
  input  logic [COOR_W-1:0] i_dst_y,
  input  logic              i_end,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [COOR_W-1:0] o_src_x,
  output logic [COOR_W-1:0] o_src_y,
  output logic [COOR_W-1:0] o_dst_x,
  output logic [COOR_W-1:0] o_dst_y,
  output logic              o_sum_valid,
  output logic [CNT_W-1:0]  o_match_cnt,
  output logic [CNT_W-1:0]  o_drop_cnt,
  output logic [SUM_W-1:0]  o_sum_dx,
  output logic [SUM_W-1:0]  o_sum_dy,
  output logic              o_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = 4 * COOR_W;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [PW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic          push_s, pop_s;
  logic [PW-1:0] head_s;

  // Occupancy before this cycle's pop decides acceptance: full+pop still drops.
  assign push_s = i_valid && (fill_q != FULL_LVL);
  assign pop_s  = (fill_q != '0) && i_ready;
  assign head_s = mem_q[rd_ptr_q];

  assign o_valid = (fill_q != '0);
  assign o_src_x = head_s[4*COOR_W-1:3*COOR_W];
  assign o_src_y = head_s[3*COOR_W-1:2*COOR_W];
  assign o_dst_x = head_s[2*COOR_W-1:COOR_W];
  assign o_dst_y = head_s[COOR_W-1:0];

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  // FIFO storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {i_src_x, i_src_y, i_dst_x, i_dst_y};
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics and frame FSM
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d, cnt_upd_s;
  logic [CNT_W-1:0]  acc_drop_q, acc_drop_d, drop_upd_s;
  logic [SUM_W-1:0]  acc_dx_q, acc_dx_d, dx_upd_s;
  logic [SUM_W-1:0]  acc_dy_q, acc_dy_d, dy_upd_s;
  logic [CNT_W-1:0]  snap_cnt_q, snap_cnt_d;
  logic [CNT_W-1:0]  snap_drop_q, snap_drop_d;
  logic [SUM_W-1:0]  snap_dx_q, snap_dx_d;
  logic [SUM_W-1:0]  snap_dy_q, snap_dy_d;
  logic [COOR_W:0]   dx_s, dy_s;
  logic [SUM_W-1:0]  dx_ext_s, dy_ext_s;
  logic              frame_end_s;
  logic              report_load_s;
  logic              err_d;

  // Differences are taken at COOR_W+1 bits so the sign survives, then extended.
  assign dx_s     = {1'b0, i_dst_x} - {1'b0, i_src_x};
  assign dy_s     = {1'b0, i_dst_y} - {1'b0, i_src_y};
  assign dx_ext_s = {{(SUM_W-COOR_W-1){dx_s[COOR_W]}}, dx_s};
  assign dy_ext_s = {{(SUM_W-COOR_W-1){dy_s[COOR_W]}}, dy_s};

  assign frame_end_s = i_end && (state_q == ST_ACCUM);

  // Per-pair accumulator update; sums freeze together with a saturated count.
  always_comb begin
    cnt_upd_s  = acc_cnt_q;
    drop_upd_s = acc_drop_q;
    dx_upd_s   = acc_dx_q;
    dy_upd_s   = acc_dy_q;
    if (i_valid && (acc_cnt_q != '1)) begin
      cnt_upd_s = acc_cnt_q + 1'b1;
      dx_upd_s  = acc_dx_q + dx_ext_s;
      dy_upd_s  = acc_dy_q + dy_ext_s;
    end else begin
      cnt_upd_s = acc_cnt_q;
      dx_upd_s  = acc_dx_q;
      dy_upd_s  = acc_dy_q;
    end
    if (i_valid && !push_s && (acc_drop_q != '1)) begin
      drop_upd_s = acc_drop_q + 1'b1;
    end else begin
      drop_upd_s = acc_drop_q;
    end
  end

  // Frame boundary: snapshot includes this cycle's pair, accumulators restart.
  always_comb begin
    acc_cnt_d   = cnt_upd_s;
    acc_drop_d  = drop_upd_s;
    acc_dx_d    = dx_upd_s;
    acc_dy_d    = dy_upd_s;
    snap_cnt_d  = snap_cnt_q;
    snap_drop_d = snap_drop_q;
    snap_dx_d   = snap_dx_q;
    snap_dy_d   = snap_dy_q;
    if (frame_end_s) begin
      acc_cnt_d   = '0;
      acc_drop_d  = '0;
      acc_dx_d    = '0;
      acc_dy_d    = '0;
      snap_cnt_d  = cnt_upd_s;
      snap_drop_d = drop_upd_s;
      snap_dx_d   = dx_upd_s;
      snap_dy_d   = dy_upd_s;
    end else begin
      snap_cnt_d  = snap_cnt_q;
      snap_drop_d = snap_drop_q;
      snap_dx_d   = snap_dx_q;
      snap_dy_d   = snap_dy_q;
    end
  end

  // FSM next state; a pair entering an empty FIFO in DRAIN postpones REPORT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM: begin
        if (i_end) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_DRAIN: begin
        if ((fill_q == '0) && !push_s) begin
          state_d = ST_REPORT;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_REPORT: state_d = ST_ACCUM;
      default:   state_d = ST_ACCUM;
    endcase
  end

  assign report_load_s = (state_q == ST_DRAIN) && (state_d == ST_REPORT);
  assign err_d         = o_err || (i_end && (state_q != ST_ACCUM));

  // State registers for FIFO control, accumulators, snapshot and outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      state_q     <= ST_ACCUM;
      acc_cnt_q   <= '0;
      acc_drop_q  <= '0;
      acc_dx_q    <= '0;
      acc_dy_q    <= '0;
      snap_cnt_q  <= '0;
      snap_drop_q <= '0;
      snap_dx_q   <= '0;
      snap_dy_q   <= '0;
      o_sum_valid <= 1'b0;
      o_match_cnt <= '0;
      o_drop_cnt  <= '0;
      o_sum_dx    <= '0;
      o_sum_dy    <= '0;
      o_err       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      state_q     <= state_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_drop_q  <= acc_drop_d;
      acc_dx_q    <= acc_dx_d;
      acc_dy_q    <= acc_dy_d;
      snap_cnt_q  <= snap_cnt_d;
      snap_drop_q <= snap_drop_d;
      snap_dx_q   <= snap_dx_d;
      snap_dy_q   <= snap_dy_d;
      o_err       <= err_d;
      // The strobe coincides with the single REPORT cycle; values hold after.
      o_sum_valid <= report_load_s;
      if (report_load_s) begin
        o_match_cnt <= snap_cnt_q;
        o_drop_cnt  <= snap_drop_q;
        o_sum_dx    <= snap_dx_q;
        o_sum_dy    <= snap_dy_q;
      end
    end
  end

endmodule
